// File: rtl/axi_lite_join_cut_pkg.sv
// Shared types and constants for the AXI-Lite join with per-channel cuts.
// Holds the lite channel payload structs, the bundled request/response
// structs, response encodings, channel indices and the spill-register
// state encoding.
package axi_lite_join_cut_pkg;

    localparam int unsigned AXI_ADDR_W = 32'd32;
    localparam int unsigned AXI_DATA_W = 32'd32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 32'd8;
    localparam int unsigned AXI_RESP_W = 32'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Bit positions of each channel inside the cut mask.
    localparam int unsigned CH_AW = 32'd0;
    localparam int unsigned CH_W  = 32'd1;
    localparam int unsigned CH_B  = 32'd2;
    localparam int unsigned CH_AR = 32'd3;
    localparam int unsigned CH_R  = 32'd4;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [2:0]            prot;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_RESP_W-1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [2:0]            prot;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_RESP_W-1:0] resp;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;

    // Spill register occupancy: EMPTY, ONE (slot A full), TWO (A and B full).
    typedef enum logic [1:0] {
        SPILL_EMPTY = 2'd0,
        SPILL_ONE   = 2'd1,
        SPILL_TWO   = 2'd2
    } spill_state_e;

    // Returns 1 when the given channel is selected for a register cut.
    function automatic logic is_cut(input logic [31:0] mask, input int unsigned ch);
        return mask[ch];
    endfunction

endpackage

// File: rtl/axi_lite_join_cut_if.sv
// AXI-Lite port bundle: one request struct and one response struct.
// The master side drives requests, the slave side drives responses.
interface axi_lite_join_cut_if;
    import axi_lite_join_cut_pkg::*;

    axi_req_t  req;
    axi_resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/axi_lite_join_cut_spill_reg.sv
// Two-entry spill register for one valid/ready channel.
// Slot A feeds the output; slot B absorbs the beat that arrives while the
// output is stalled. in_ready depends only on the slot-B state, so no
// combinational path runs from out_ready back to in_ready. With Bypass set
// the channel is plain wires.
module axi_lite_join_cut_spill_reg
    import axi_lite_join_cut_pkg::*;
#(
    parameter bit  Bypass = 1'b0,
    parameter type T      = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    if (Bypass) begin : g_bypass
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk ^ rst_n;
        assign out_valid        = in_valid;
        assign in_ready         = out_ready;
        assign out_data         = in_data;
    end else begin : g_cut
        spill_state_e state_r;
        spill_state_e state_nxt_s;
        T             a_data_r;
        T             b_data_r;
        logic         a_load_in_s;
        logic         a_load_b_s;
        logic         b_load_in_s;

        // Occupancy state register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= SPILL_EMPTY;
            end else begin
                state_r <= state_nxt_s;
            end
        end

        // Next occupancy and slot load strobes from the two handshakes.
        always_comb begin
            state_nxt_s = state_r;
            a_load_in_s = 1'b0;
            a_load_b_s  = 1'b0;
            b_load_in_s = 1'b0;
            case (state_r)
                SPILL_EMPTY: begin
                    if (in_valid) begin
                        a_load_in_s = 1'b1;
                        state_nxt_s = SPILL_ONE;
                    end else begin
                        state_nxt_s = SPILL_EMPTY;
                    end
                end
                SPILL_ONE: begin
                    if (in_valid && out_ready) begin
                        a_load_in_s = 1'b1;
                        state_nxt_s = SPILL_ONE;
                    end else if (in_valid) begin
                        b_load_in_s = 1'b1;
                        state_nxt_s = SPILL_TWO;
                    end else if (out_ready) begin
                        state_nxt_s = SPILL_EMPTY;
                    end else begin
                        state_nxt_s = SPILL_ONE;
                    end
                end
                SPILL_TWO: begin
                    if (out_ready) begin
                        a_load_b_s  = 1'b1;
                        state_nxt_s = SPILL_ONE;
                    end else begin
                        state_nxt_s = SPILL_TWO;
                    end
                end
                default: begin
                    state_nxt_s = SPILL_EMPTY;
                end
            endcase
        end

        // Output slot: takes a fresh input beat or the spilled beat from B.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_data_r <= '0;
            end else if (a_load_in_s) begin
                a_data_r <= in_data;
            end else if (a_load_b_s) begin
                a_data_r <= b_data_r;
            end else begin
                a_data_r <= a_data_r;
            end
        end

        // Overflow slot: filled when A is stalled, cleared when it drains into A.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                b_data_r <= '0;
            end else if (b_load_in_s) begin
                b_data_r <= in_data;
            end else if (a_load_b_s) begin
                b_data_r <= '0;
            end else begin
                b_data_r <= b_data_r;
            end
        end

        assign out_valid = (state_r != SPILL_EMPTY);
        assign in_ready  = (state_r != SPILL_TWO);
        assign out_data  = a_data_r;
    end

endmodule

// File: rtl/axi_lite_join_cut.sv
// AXI-Lite join with an optional spill-register cut on each of the five
// channels. A set bit in CutMask ({R,AR,B,W,AW} = bits 4..0) puts a
// one-cycle, full-throughput register stage on that channel; a clear bit
// leaves it as wires. Channels are independent; AW/W ordering is not
// enforced here.
module axi_lite_join_cut
    import axi_lite_join_cut_pkg::*;
#(
    parameter int unsigned AddrWidth = AXI_ADDR_W,
    parameter int unsigned DataWidth = AXI_DATA_W,
    parameter int unsigned CutMask   = 32'h0000_001F
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    axi_lite_join_cut_if.slave   slv,
    axi_lite_join_cut_if.master  mst
);

    // Elaboration-time parameter sanity.
    if ((DataWidth % 32'd8) != 32'd0 || DataWidth < 32'd32) begin : g_bad_data_width
        $error("axi_lite_join_cut: DataWidth must be a multiple of 8 and at least 32");
    end
    if (DataWidth != AXI_DATA_W || AddrWidth != AXI_ADDR_W) begin : g_bad_struct_width
        $error("axi_lite_join_cut: widths must match the shared channel structs");
    end
    if (CutMask >= 32'd32) begin : g_bad_cut_mask
        $error("axi_lite_join_cut: CutMask must be below 32");
    end

    aw_chan_t mst_aw_s;
    logic     mst_aw_valid_s;
    logic     slv_aw_ready_s;
    w_chan_t  mst_w_s;
    logic     mst_w_valid_s;
    logic     slv_w_ready_s;
    b_chan_t  slv_b_s;
    logic     slv_b_valid_s;
    logic     mst_b_ready_s;
    ar_chan_t mst_ar_s;
    logic     mst_ar_valid_s;
    logic     slv_ar_ready_s;
    r_chan_t  slv_r_s;
    logic     slv_r_valid_s;
    logic     mst_r_ready_s;

    axi_lite_join_cut_spill_reg #(
        .Bypass (!is_cut(CutMask, CH_AW)),
        .T      (aw_chan_t)
    ) u_aw (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (slv.req.aw_valid),
        .in_ready  (slv_aw_ready_s),
        .in_data   (slv.req.aw),
        .out_valid (mst_aw_valid_s),
        .out_ready (mst.resp.aw_ready),
        .out_data  (mst_aw_s)
    );

    axi_lite_join_cut_spill_reg #(
        .Bypass (!is_cut(CutMask, CH_W)),
        .T      (w_chan_t)
    ) u_w (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (slv.req.w_valid),
        .in_ready  (slv_w_ready_s),
        .in_data   (slv.req.w),
        .out_valid (mst_w_valid_s),
        .out_ready (mst.resp.w_ready),
        .out_data  (mst_w_s)
    );

    // Response channels flow from the downstream slave to the upstream master.
    axi_lite_join_cut_spill_reg #(
        .Bypass (!is_cut(CutMask, CH_B)),
        .T      (b_chan_t)
    ) u_b (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (mst.resp.b_valid),
        .in_ready  (mst_b_ready_s),
        .in_data   (mst.resp.b),
        .out_valid (slv_b_valid_s),
        .out_ready (slv.req.b_ready),
        .out_data  (slv_b_s)
    );

    axi_lite_join_cut_spill_reg #(
        .Bypass (!is_cut(CutMask, CH_AR)),
        .T      (ar_chan_t)
    ) u_ar (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (slv.req.ar_valid),
        .in_ready  (slv_ar_ready_s),
        .in_data   (slv.req.ar),
        .out_valid (mst_ar_valid_s),
        .out_ready (mst.resp.ar_ready),
        .out_data  (mst_ar_s)
    );

    axi_lite_join_cut_spill_reg #(
        .Bypass (!is_cut(CutMask, CH_R)),
        .T      (r_chan_t)
    ) u_r (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .in_valid  (mst.resp.r_valid),
        .in_ready  (mst_r_ready_s),
        .in_data   (mst.resp.r),
        .out_valid (slv_r_valid_s),
        .out_ready (slv.req.r_ready),
        .out_data  (slv_r_s)
    );

    assign mst.req = '{
        aw:       mst_aw_s,
        aw_valid: mst_aw_valid_s,
        w:        mst_w_s,
        w_valid:  mst_w_valid_s,
        b_ready:  mst_b_ready_s,
        ar:       mst_ar_s,
        ar_valid: mst_ar_valid_s,
        r_ready:  mst_r_ready_s
    };

    assign slv.resp = '{
        aw_ready: slv_aw_ready_s,
        w_ready:  slv_w_ready_s,
        b:        slv_b_s,
        b_valid:  slv_b_valid_s,
        ar_ready: slv_ar_ready_s,
        r:        slv_r_s,
        r_valid:  slv_r_valid_s
    };

endmodule
